pc_ctrl: RTL

Fetch-redirect and stall controller for the core front end. It sits between the execute stage, the exception/interrupt sources and the pipeline hazard detectors on one side, and `pc` plus the pipeline registers on the other. Each cycle it decides:

- which single redirect, if any, reaches `pc`;
- which hold level the pipeline sees;
- how long wrong-path instructions are squashed after a redirect.

It also owns interrupt acceptance and the EPC capture register.

---
 rtl/pc_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pc_ctrl.sv
// Front-end redirect arbiter and stall/flush controller.
// Picks one redirect per cycle, drives pipeline hold levels, times the wrong-path squash and owns EPC.
module pc_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ex_jump_cause_i,
  input  logic [ADDR_W-1:0] ex_jump_from_addr_i,
  input  logic [ADDR_W-1:0] ex_jump_to_addr_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic              ex_valid_i,
  input  logic              exc_req_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  input  logic              irq_req_i,
  input  logic [ADDR_W-1:0] irq_vec_i,
  input  logic              mret_i,
  input  logic              mem_busy_i,
  input  logic              md_busy_i,
  input  logic              ld_use_i,
  output logic [2:0]        jump_cause_o,
  output logic [ADDR_W-1:0] jump_from_addr_o,
  output logic [ADDR_W-1:0] jump_to_addr_o,
  output logic [2:0]        hold_flag_o,
  output logic              flush_o,
  output logic              irq_ack_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic              in_trap_o
);

  localparam int unsigned CNT_W = 3;
  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_IRQ  = 3'd4;
  localparam logic [2:0] CAUSE_EXC  = 3'd5;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_STALL} state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_flush;
  logic               r_in_trap;
  logic [ADDR_W-1:0]  r_epc;

  logic [2:0] w_hold_lvl;
  logic       w_hold_any;
  logic       w_in_flush;
  logic       w_exc_take;
  logic       w_ex_take;
  logic       w_irq_take;
  logic       w_redirect;

  // Hazard level and redirect arbitration; wrong-path requests are ignored while flushing.
  always_comb begin
    w_hold_lvl = 3'b000;
    if (mem_busy_i || md_busy_i) w_hold_lvl = 3'b111;
    else if (ld_use_i)           w_hold_lvl = 3'b011;
    w_hold_any = |w_hold_lvl;
    w_in_flush = (r_state == S_FLUSH);
    w_exc_take = rst_n && exc_req_i && ex_valid_i && !w_in_flush;
    w_ex_take  = rst_n && (ex_jump_cause_i != CAUSE_NONE) && ex_valid_i
                 && !w_in_flush && !w_exc_take;
    w_irq_take = rst_n && irq_req_i && !r_in_trap && (r_state == S_RUN)
                 && !w_hold_any && ex_valid_i && !w_exc_take && !w_ex_take;
    w_redirect = w_exc_take || w_ex_take || w_irq_take;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and squash counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_RUN: begin
        if (w_redirect) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
        end else if (w_hold_any) begin
          w_state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (w_exc_take || w_ex_take) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
        end else if (!w_hold_any) begin
          w_state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        if (r_cnt == '0) w_state_nxt = w_hold_any ? S_STALL : S_RUN;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Same-cycle redirect payload and hold levels.
  always_comb begin
    jump_cause_o     = CAUSE_NONE;
    jump_from_addr_o = '0;
    jump_to_addr_o   = '0;
    irq_ack_o        = 1'b0;
    hold_flag_o      = '0;
    if (w_exc_take) begin
      jump_cause_o     = CAUSE_EXC;
      jump_from_addr_o = ex_pc_i;
      jump_to_addr_o   = trap_vec_i;
    end else if (w_ex_take) begin
      jump_cause_o     = ex_jump_cause_i;
      jump_from_addr_o = ex_jump_from_addr_i;
      jump_to_addr_o   = ex_jump_to_addr_i;
    end else if (w_irq_take) begin
      jump_cause_o     = CAUSE_IRQ;
      jump_from_addr_o = ex_pc_i;
      jump_to_addr_o   = irq_vec_i;
      irq_ack_o        = 1'b1;
    end
    if (rst_n && !w_redirect && !w_in_flush) hold_flag_o = w_hold_lvl;
  end

  // Registered squash flag and trap bookkeeping; trap entry beats a coincident mret.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush   <= 1'b0;
      r_in_trap <= 1'b0;
      r_epc     <= '0;
    end else begin
      r_flush <= (w_state_nxt == S_FLUSH);
      if (w_exc_take || w_irq_take) begin
        r_epc     <= ex_pc_i;
        r_in_trap <= 1'b1;
      end else if (mret_i) begin
        r_in_trap <= 1'b0;
      end
    end
  end

  assign flush_o   = r_flush;
  assign in_trap_o = r_in_trap;
  assign epc_o     = r_epc;

endmodule
